// File: rtl/twos_comp_in.sv
// twos_comp_in: keypad BCD digit/sign entry to sign-magnitude, committed as int16 two's complement.
// Optional TWOS_COMP_IN_ECHO_EN adds o_echo, a registered live view of the pending entry.
package twos_comp_in_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, TEN = 2'd1} segment_e;
endpackage

module twos_comp_in
  import twos_comp_in_pkg::*;
#(
  parameter int MAX_DIGITS = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_digit,
  input  logic        i_digit_valid,
  input  logic        i_sign_key,
  input  logic        i_enter,
  input  logic        i_clear,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_ready,
  output logic        o_overflow,
  output logic [2:0]  o_digits,
  output segment_e    o_sign
`ifdef TWOS_COMP_IN_ECHO_EN
  ,
  output logic [15:0] o_echo
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CONV} state_e;
  state_e      state_q, state_d;
  logic [15:0] mag_q, mag_d, data_q, data_d;
  logic        neg_q, neg_d, valid_q, valid_d, ovf_q, ovf_d;
  logic [2:0]  digits_q, digits_d;
  logic [19:0] new_w, limit_w;
  logic        accept_w;
  assign new_w    = {4'd0, mag_q} * 20'd10 + {16'd0, i_digit};
  assign limit_w  = neg_q ? 20'd32768 : 20'd32767;
  assign accept_w = new_w <= limit_w && digits_q < 3'(MAX_DIGITS);
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    valid_d  = 1'b0;
    if (state_q == S_CONV) begin
      data_d   = neg_q ? ~mag_q + 16'd1 : mag_q;
      valid_d  = 1'b1;
      state_d  = S_IDLE;
      mag_d    = '0;
      neg_d    = 1'b0;
      ovf_d    = 1'b0;
      digits_d = '0;
    end else if (i_clear) begin
      state_d  = S_IDLE;
      mag_d    = '0;
      neg_d    = 1'b0;
      ovf_d    = 1'b0;
      digits_d = '0;
    end else if (i_enter) begin
      state_d = S_CONV;
    end else if (i_sign_key) begin
      state_d = S_ENTRY;
      neg_d   = !neg_q;
      // -32768 has no positive counterpart: clamp when flipping back
      if (neg_q && mag_q == 16'h8000) begin
        mag_d = 16'h7FFF;
        ovf_d = 1'b1;
      end
    end else if (i_digit_valid && i_digit <= 4'd9) begin
      state_d = S_ENTRY;
      if (accept_w) begin
        mag_d    = new_w[15:0];
        digits_d = (mag_q == '0 && i_digit == 4'd0) ? digits_q : digits_q + 3'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
    end
  end
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_ready    = state_q != S_CONV;
  assign o_overflow = ovf_q;
  assign o_digits   = digits_q;
  assign o_sign     = neg_q ? TEN : OFF;
`ifdef TWOS_COMP_IN_ECHO_EN
  logic [15:0] echo_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) echo_q <= '0;
    else echo_q <= neg_d ? ~mag_d + 16'd1 : mag_d;
  end
  assign o_echo = echo_q;
`endif
endmodule

// File: tb/tb_twos_comp_in.sv
// tb_twos_comp_in: integer reference model checked every cycle plus directed literal checks.
module tb_twos_comp_in;
  import twos_comp_in_pkg::*;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  digit = 0;
  logic        dv = 0, sk = 0, en = 0, cl = 0;
  logic [15:0] data;
  logic        valid, ready, ovf;
  logic [2:0]  digits;
  segment_e    sign;
`ifdef TWOS_COMP_IN_ECHO_EN
  logic [15:0] echo;
`endif
  twos_comp_in dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_digit(digit), .i_digit_valid(dv),
    .i_sign_key(sk), .i_enter(en), .i_clear(cl), .o_data(data), .o_valid(valid),
    .o_ready(ready), .o_overflow(ovf), .o_digits(digits), .o_sign(sign)
`ifdef TWOS_COMP_IN_ECHO_EN
    , .o_echo(echo)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, vpulses = 0;
  bit chk_on = 0;
  int m_mag = 0, m_digits = 0;
  bit m_neg = 0, m_ovf = 0, m_valid = 0, m_conv = 0;
  logic [15:0] m_data = 0;
  function automatic logic [15:0] as_int16(int mag, bit neg);
    int v;
    v = neg ? -mag : mag;
    return v[15:0];
  endfunction
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    int nv;
    if (!rst_n) begin
      m_mag = 0; m_digits = 0; m_neg = 0; m_ovf = 0; m_valid = 0; m_conv = 0; m_data = 0;
    end else if (m_conv) begin
      m_data = as_int16(m_mag, m_neg);
      m_valid = 1; m_conv = 0;
      m_mag = 0; m_digits = 0; m_neg = 0; m_ovf = 0;
    end else begin
      m_valid = 0;
      if (cl) begin
        m_mag = 0; m_digits = 0; m_neg = 0; m_ovf = 0;
      end else if (en) m_conv = 1;
      else if (sk) begin
        if (m_neg && m_mag == 32768) begin m_mag = 32767; m_ovf = 1; end
        m_neg = !m_neg;
      end else if (dv && digit < 10) begin
        nv = m_mag * 10 + int'(digit);
        if (nv <= (m_neg ? 32768 : 32767) && m_digits < 5) begin
          if (!(m_mag == 0 && digit == 0)) m_digits++;
          m_mag = nv;
        end else m_ovf = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (valid === 1'b1) vpulses++;
    if (chk_on) begin
      chk("data", data, m_data);
      chk("valid", 16'(valid), 16'(m_valid));
      chk("ready", 16'(ready), 16'(!m_conv));
      chk("overflow", 16'(ovf), 16'(m_ovf));
      chk("digits", 16'(digits), 16'(m_digits));
      chk("sign", 16'(sign), 16'(m_neg ? TEN : OFF));
`ifdef TWOS_COMP_IN_ECHO_EN
      chk("echo", echo, as_int16(m_mag, m_neg));
`endif
    end
  end
  task automatic pulse(input logic d_v, input logic [3:0] d, input logic s, input logic e, input logic c);
    @(negedge clk);
    dv = d_v; digit = d; sk = s; en = e; cl = c;
    @(posedge clk); #1;
    dv = 0; digit = 0; sk = 0; en = 0; cl = 0;
  endtask
  task automatic key(input logic [3:0] d);
    pulse(1, d, 0, 0, 0);
  endtask
  task automatic commit(input string name, input logic [15:0] exp);
    pulse(0, 0, 0, 1, 0);
    @(negedge clk);
    chk({name, "_busy"}, 16'(ready), 16'd0);
    @(negedge clk);
    chk({name, "_valid"}, 16'(valid), 16'd1);
    chk(name, data, exp);
    @(negedge clk);
    chk({name, "_vdrop"}, 16'(valid), 16'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1; chk_on = 1;
    repeat (5) @(negedge clk);
    chk("rst_data", data, 16'h0000);
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_sign", 16'(sign), 16'(OFF));
    chk("rst_digits", 16'(digits), 16'd0);
    key(1); key(2); key(3);
    commit("d123", 16'h007B);
    pulse(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("neg_sign", 16'(sign), 16'(TEN));
    key(3); key(2); key(7); key(6); key(8);
    @(negedge clk);
    chk("neg_ovf", 16'(ovf), 16'd0);
    chk("neg_digits", 16'(digits), 16'd5);
    commit("neg32768", 16'h8000);
    key(3); key(2); key(7); key(6); key(8);
    @(negedge clk);
    chk("pos_ovf", 16'(ovf), 16'd1);
    chk("pos_digits", 16'(digits), 16'd4);
    commit("pos3276", 16'h0CCC);
    pulse(1, 5, 0, 0, 1);
    @(negedge clk);
    chk("clr_digits", 16'(digits), 16'd0);
    commit("clr_commit", 16'h0000);
    key(4);
    commit("d4", 16'h0004);
    pulse(1, 9, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("dig_enter", data, 16'h0000);
    key(0); key(0); key(4); key(12); key(2);
    @(negedge clk);
    chk("lead_digits", 16'(digits), 16'd2);
    commit("lead42", 16'h002A);
    pulse(0, 0, 1, 0, 0);
    key(3); key(2); key(7); key(6); key(8);
    pulse(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("clamp_ovf", 16'(ovf), 16'd1);
    chk("clamp_sign", 16'(sign), 16'(OFF));
    commit("clamp", 16'h7FFF);
    pulse(0, 0, 1, 0, 0);
    commit("neg_zero", 16'h0000);
    key(9);
    pulse(0, 0, 0, 1, 0);
    pulse(1, 7, 0, 0, 0);
    @(negedge clk);
    chk("busy_ignore", data, 16'h0009);
    chk("busy_digits", 16'(digits), 16'd0);
    pulse(0, 0, 1, 0, 0);
    key(1); key(2);
    pulse(0, 0, 0, 1, 0);
    rst_n = 0;
    vpulses = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("rst_conv_pulses", 16'(vpulses), 16'd0);
    chk("rst_conv_data", data, 16'h0000);
    chk("rst_conv_ready", 16'(ready), 16'd1);
    chk("rst_conv_sign", 16'(sign), 16'(OFF));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
